dc_fifo_af_ae: RTL and testbench

// - Synchronous FIFO with programmable almost-full and almost-empty thresholds.
// - Buffers samples into and out of the quadratic interpolator core in stream mode.
// - The input instance feeds the core and gives it Empty.
// - The output instance takes core results and gives the core Almost_Full for back-pressure.

---
 rtl/dc_fifo_af_ae.sv | 76 +++++++
 tb/tb_dc_fifo_af_ae.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dc_fifo_af_ae.sv
// Synchronous FIFO with programmable almost-full / almost-empty thresholds.
// Pointers carry an extra wrap bit so that full and empty can be told apart
// without a separate counter; flags are decoded combinationally from the
// registered pointers and the live threshold inputs.
module dc_fifo_af_ae #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Write_enable_i,
  input  logic                  Read_enable__i,
  input  logic [ADDR_WIDTH-1:0] differenceAF_i,
  input  logic [ADDR_WIDTH-1:0] differenceAE_i,
  input  logic [DATA_WIDTH-1:0] data_input___i,
  output logic [DATA_WIDTH-1:0] data_output__o,
  output logic                  Empty_Indica_o,
  output logic                  Full_Indicat_o,
  output logic                  Almost_Full__o,
  output logic                  Almost_Empty_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // DEPTH expressed in pointer width (wrap bit set, address bits clear).
  localparam logic [ADDR_WIDTH:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_P   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_r;
  logic [ADDR_WIDTH:0]   rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  // Status flags and accept decisions, all taken from the pre-edge state.
  always_comb begin
    count_s        = wr_ptr_r - rd_ptr_r;
    Empty_Indica_o = (wr_ptr_r == rd_ptr_r);
    Full_Indicat_o = (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
                     (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]);
    Almost_Full__o = (count_s >= (DEPTH_P - {1'b0, differenceAF_i}));
    Almost_Empty_o = (count_s <= {1'b0, differenceAE_i});
    // A full FIFO drops the write even when a read is accepted alongside it.
    wr_acc_s       = Write_enable_i & ~Full_Indicat_o;
    rd_acc_s       = Read_enable__i & ~Empty_Indica_o;
  end

  // Storage array: written on accepted writes only, never reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= data_input___i;
    end
  end

  // Write pointer: advances on each accepted write, wraps modulo 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(ADDR_WIDTH+1){1'b0}};
    end else if (wr_acc_s) begin
      wr_ptr_r <= wr_ptr_r + ONE_P;
    end
  end

  // Read pointer and registered read data: the word appears on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r       <= {(ADDR_WIDTH+1){1'b0}};
      data_output__o <= {DATA_WIDTH{1'b0}};
    end else if (rd_acc_s) begin
      rd_ptr_r       <= rd_ptr_r + ONE_P;
      data_output__o <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
    end
  end

endmodule

// File: tb/tb_dc_fifo_af_ae.sv
// Self-checking bench for dc_fifo_af_ae: a table of {request, expected flag}
// vectors drives the FIFO, a reference queue predicts which words a read
// returns, and a scoreboard queue holds the read data still to be compared.
module tb_dc_fifo_af_ae;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] diff_af;
  logic [AW-1:0] diff_ae;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic          afull;
  logic          aempty;

  dc_fifo_af_ae #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .Write_enable_i (wr_en),
    .Read_enable__i (rd_en),
    .differenceAF_i (diff_af),
    .differenceAE_i (diff_ae),
    .data_input___i (din),
    .data_output__o (dout),
    .Empty_Indica_o (empty),
    .Full_Indicat_o (full),
    .Almost_Full__o (afull),
    .Almost_Empty_o (aempty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] d;
    logic          e;
    logic          f;
    logic          af;
    logic          ae;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] held_dout;
  int            n_vec;
  int            n_err;

  task automatic add(input logic wr, input logic rd, input logic [DW-1:0] d,
                     input logic e, input logic f, input logic af, input logic ae);
    vec_t v;
    v.wr = wr; v.rd = rd; v.d = d; v.e = e; v.f = f; v.af = af; v.ae = ae;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag, input logic e, input logic f,
                       input logic af, input logic ae, input logic [DW-1:0] dexp);
    n_vec++;
    if (empty !== e)  begin n_err++; $display("FAIL %s empty got %b want %b", tag, empty, e); end
    if (full !== f)   begin n_err++; $display("FAIL %s full got %b want %b", tag, full, f); end
    if (afull !== af) begin n_err++; $display("FAIL %s afull got %b want %b", tag, afull, af); end
    if (aempty !== ae) begin n_err++; $display("FAIL %s aempty got %b want %b", tag, aempty, ae); end
    if (dout !== dexp) begin n_err++; $display("FAIL %s dout got %h want %h", tag, dout, dexp); end
  endtask

  // Drive one vector across one clock edge; the reference queue decides
  // acceptance from the pre-edge occupancy, exactly as the FIFO must.
  task automatic step(input string tag, input vec_t v);
    logic rd_ok;
    logic wr_ok;
    wr_en = v.wr;
    rd_en = v.rd;
    din   = v.d;
    rd_ok = v.rd && (model_q.size() > 0);
    wr_ok = v.wr && (model_q.size() < DEPTH);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(v.d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (exp_q.size() > 0) held_dout = exp_q.pop_front();
    check(tag, v.e, v.f, v.af, v.ae, held_dout);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    held_dout = 32'h0000_0000;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    diff_af = 3'd2; diff_ae = 3'd2; din = 32'h0000_0000;

    // Vector table: thresholds 2/2, so AF at count >= 6, AE at count <= 2.
    // Three writes then three reads.
    add(1'b1, 1'b0, 32'h0000_00A1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 32'h0000_00A2, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 32'h0000_00A3, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    // Read while empty holds data; a following write/read still works.
    add(1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 32'h0000_00B1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    // Simultaneous at empty: only the write happens.
    add(1'b1, 1'b1, 32'h0000_00C0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    // Fill to full: AF on the 6th write, Full on the 8th.
    add(1'b1, 1'b0, 32'h0000_00D1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 32'h0000_00D2, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 32'h0000_00D3, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 32'h0000_00D4, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 32'h0000_00D5, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 32'h0000_00D6, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 32'h0000_00D7, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 32'h0000_00D8, 1'b0, 1'b1, 1'b1, 1'b0);
    // 9th write is dropped.
    add(1'b1, 1'b0, 32'h0000_00D9, 1'b0, 1'b1, 1'b1, 1'b0);
    // Simultaneous at full: only the read happens (returns D1), DA dropped.
    add(1'b1, 1'b1, 32'h0000_00DA, 1'b0, 1'b0, 1'b1, 1'b0);
    // Drain to count 4.
    add(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    // Simultaneous at count 4: count stays 4.
    add(1'b1, 1'b1, 32'h0000_00E1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Drain remainder: D6, D7, D8, E1.
    add(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    // Wrap: 20 interleaved write/read pairs of 1..20.
    for (int i = 1; i <= 20; i++) begin
      add(1'b1, 1'b0, DW'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    end

    // Reset state, checked while reset is held and after release.
    #12;
    check("reset_held", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_released", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end
    if (model_q.size() != 0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain model=%0d pending=%0d want 0/0", model_q.size(), exp_q.size());
    end

    // Live threshold changes at count 3 affect AF/AE without a clock edge.
    begin
      vec_t v;
      v.rd = 1'b0; v.wr = 1'b1; v.e = 1'b0; v.f = 1'b0; v.af = 1'b0;
      v.d = 32'h0000_0F01; v.ae = 1'b1; step("thr_w1", v);
      v.d = 32'h0000_0F02; v.ae = 1'b1; step("thr_w2", v);
      v.d = 32'h0000_0F03; v.ae = 1'b0; step("thr_w3", v);
    end
    diff_ae = 3'd3; diff_af = 3'd5;
    #1;
    check("thr_raise", 1'b0, 1'b0, 1'b1, 1'b1, held_dout);
    diff_ae = 3'd0; diff_af = 3'd0;
    #1;
    check("thr_zero", 1'b0, 1'b0, 1'b0, 1'b0, held_dout);
    diff_ae = 3'd2; diff_af = 3'd2;

    // Reset mid-stream: flags and data clear before any clock edge.
    wr_en = 1'b1; din = 32'h0000_0F04;
    model_q.push_back(32'h0000_0F04);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    held_dout = model_q.pop_front();
    check("pre_rst_read", 1'b0, 1'b0, 1'b0, 1'b0, held_dout);
    rst = 1'b1;
    #2;
    model_q.delete();
    exp_q.delete();
    held_dout = 32'h0000_0000;
    check("rst_midstream", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    begin
      vec_t v;
      v.wr = 1'b1; v.rd = 1'b0; v.d = 32'h0000_1234;
      v.e = 1'b0; v.f = 1'b0; v.af = 1'b0; v.ae = 1'b1;
      step("post_rst_w", v);
      v.wr = 1'b0; v.rd = 1'b1; v.d = 32'h0000_0000; v.e = 1'b1;
      step("post_rst_r", v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
